// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// Data has fixed priority; a streak limit guarantees a pending fetch is eventually served.
module mem_port_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,

  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,

  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int unsigned StreakW = $clog2(MAX_DSTREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } state_t;

  state_t             state;
  logic [StreakW-1:0] dstreak;

  logic i_req;
  logic d_req;
  logic streak_ok;
  logic grant_d;
  logic grant_i;

  assign i_req     = |imem_rmask;
  assign d_req     = (|dmem_rmask) | (|dmem_wmask);
  assign streak_ok = (dstreak < StreakMax);
  assign grant_d   = d_req && (!i_req || streak_ok);
  assign grant_i   = !grant_d && i_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      dstreak   <= '0;
      mem_addr  <= '0;
      mem_rmask <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (grant_d) begin
            state     <= StBusyD;
            mem_addr  <= dmem_addr;
            mem_rmask <= dmem_rmask;
            mem_wmask <= dmem_wmask;
            mem_wdata <= dmem_wdata;
            // The streak only counts data grants that overtook a waiting fetch.
            if (!i_req) begin
              dstreak <= '0;
            end else if (dstreak != StreakMax) begin
              dstreak <= dstreak + 1'b1;
            end
          end else if (grant_i) begin
            state     <= StBusyI;
            mem_addr  <= imem_addr;
            mem_rmask <= imem_rmask;
            mem_wmask <= '0;
            dstreak   <= '0;
          end
        end
        StBusyI, StBusyD: begin
          // Always pass through idle after a response; no back-to-back grants.
          if (mem_resp) begin
            state     <= StIdle;
            mem_rmask <= '0;
            mem_wmask <= '0;
          end
        end
        default: begin
          state     <= StIdle;
          mem_rmask <= '0;
          mem_wmask <= '0;
        end
      endcase
    end
  end

  // Responses are routed combinationally; a response while idle is dropped.
  always_comb begin
    imem_resp  = 1'b0;
    imem_rdata = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    if (mem_resp) begin
      if (state == StBusyI) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_rdata;
      end else if (state == StBusyD) begin
        dmem_resp  = 1'b1;
        dmem_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then randomized
// traffic checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int MaxDstreak = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr = '0;
  logic [3:0]  imem_rmask = '0;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr = '0;
  logic [3:0]  dmem_rmask = '0;
  logic [3:0]  dmem_wmask = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  bit          m_busy;
  bit          m_own_d;
  int          m_streak;
  logic [31:0] m_addr;
  logic [3:0]  m_rmask;
  logic [3:0]  m_wmask;
  logic [31:0] m_wdata;
  int          lat;
  bit          i_pend;
  bit          d_pend;
  bit          new_grant;
  bit          glog[$];

  mem_port_arbiter #(.MAX_DSTREAK(MaxDstreak)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_addr   (mem_addr),
    .mem_rmask  (mem_rmask),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    imem_rmask = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    mem_resp   = 1'b0;
    m_busy     = 0;
    m_streak   = 0;
    i_pend     = 0;
    d_pend     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n, input bit contend);
    bit ireq;
    bit dreq;
    bit exp_i;
    bit exp_d;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      new_grant = 0;
      // Model reacts to the inputs that were present at this edge.
      if (m_busy) begin
        if (mem_resp) begin
          m_busy = 0;
          if (m_own_d) d_pend = 0;
          else i_pend = 0;
        end
      end else begin
        ireq = |imem_rmask;
        dreq = (|dmem_rmask) || (|dmem_wmask);
        if (dreq && (!ireq || m_streak < MaxDstreak)) begin
          m_busy = 1; m_own_d = 1; new_grant = 1;
          m_addr = dmem_addr; m_rmask = dmem_rmask; m_wmask = dmem_wmask;
          m_wdata = dmem_wdata;
          m_streak = ireq ? ((m_streak < MaxDstreak) ? m_streak + 1 : MaxDstreak) : 0;
          lat = contend ? 0 : int'($urandom_range(0, 3));
        end else if (ireq) begin
          m_busy = 1; m_own_d = 0; new_grant = 1;
          m_addr = imem_addr; m_rmask = imem_rmask; m_wmask = 4'h0;
          m_streak = 0;
          lat = contend ? 0 : int'($urandom_range(0, 3));
        end
      end
      #1;
      if (!i_pend) begin
        if (contend || $urandom_range(0, 2) == 0) begin
          i_pend     = 1;
          imem_addr  = 32'h6000_0000 | ($urandom & 32'h00ff_fffc);
          imem_rmask = contend ? 4'hf : 4'($urandom_range(1, 15));
        end else begin
          imem_rmask = 4'h0;
        end
      end
      if (!d_pend) begin
        if (contend || $urandom_range(0, 2) == 0) begin
          d_pend     = 1;
          dmem_addr  = $urandom & 32'h0fff_fffc;
          dmem_wdata = $urandom;
          if (contend || $urandom_range(0, 1) == 0) begin
            dmem_wmask = contend ? 4'hf : 4'($urandom_range(1, 15));
            dmem_rmask = 4'h0;
          end else begin
            dmem_rmask = 4'($urandom_range(1, 15));
            dmem_wmask = 4'h0;
          end
        end else begin
          dmem_rmask = 4'h0;
          dmem_wmask = 4'h0;
        end
      end
      mem_rdata = $urandom;
      if (m_busy) begin
        if (lat == 0) begin
          mem_resp = 1'b1;
        end else begin
          mem_resp = 1'b0;
          lat--;
        end
      end else begin
        mem_resp = !contend && ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      exp_i = m_busy && !m_own_d && mem_resp;
      exp_d = m_busy && m_own_d && mem_resp;
      chk("rnd_mem_rmask", 32'(mem_rmask), m_busy ? 32'(m_rmask) : 32'h0);
      chk("rnd_mem_wmask", 32'(mem_wmask), m_busy ? 32'(m_wmask) : 32'h0);
      if (m_busy) chk("rnd_mem_addr", mem_addr, m_addr);
      if (m_busy && m_own_d) chk("rnd_mem_wdata", mem_wdata, m_wdata);
      chk("rnd_imem_resp", 32'(imem_resp), 32'(exp_i));
      chk("rnd_imem_rdata", imem_rdata, exp_i ? mem_rdata : 32'h0);
      chk("rnd_dmem_resp", 32'(dmem_resp), 32'(exp_d));
      chk("rnd_dmem_rdata", dmem_rdata, exp_d ? mem_rdata : 32'h0);
      if (contend && new_grant) glog.push_back(mem_addr[31:28] == 4'h6);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_rmask", 32'(mem_rmask), 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_imem_resp", 32'(imem_resp), 32'h0);
    chk("rst_dmem_resp", 32'(dmem_resp), 32'h0);
    chk("rst_imem_rdata", imem_rdata, 32'h0);
    chk("rst_dmem_rdata", dmem_rdata, 32'h0);
    rst = 1'b0;

    // Single instruction read, response two cycles after issue
    step(); imem_addr = 32'h6000_0000; imem_rmask = 4'hf;
    @(negedge clk); chk("i_pre_rmask", 32'(mem_rmask), 32'h0);
    step(); @(negedge clk);
    chk("i_addr", mem_addr, 32'h6000_0000);
    chk("i_rmask", 32'(mem_rmask), 32'hf);
    chk("i_wmask", 32'(mem_wmask), 32'h0);
    chk("i_resp_early", 32'(imem_resp), 32'h0);
    step(); @(negedge clk); chk("i_resp_wait", 32'(imem_resp), 32'h0);
    step(); mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("i_resp", 32'(imem_resp), 32'h1);
    chk("i_rdata", imem_rdata, 32'h13);
    chk("i_dresp", 32'(dmem_resp), 32'h0);
    chk("i_drdata", dmem_rdata, 32'h0);
    step(); mem_resp = 1'b0; imem_rmask = 4'h0;
    @(negedge clk);
    chk("i_resp_after", 32'(imem_resp), 32'h0);
    chk("i_rmask_after", 32'(mem_rmask), 32'h0);

    // Data write; request still held at the completion edge
    step(); dmem_addr = 32'h1000; dmem_wmask = 4'hf; dmem_wdata = 32'hdead_beef;
    step(); @(negedge clk);
    chk("d_addr", mem_addr, 32'h1000);
    chk("d_wmask", 32'(mem_wmask), 32'hf);
    chk("d_wdata", mem_wdata, 32'hdead_beef);
    chk("d_rmask", 32'(mem_rmask), 32'h0);
    step(); mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("d_resp", 32'(dmem_resp), 32'h1);
    chk("d_iresp", 32'(imem_resp), 32'h0);
    step(); mem_resp = 1'b0;
    @(negedge clk);
    chk("d_no_b2b_wmask", 32'(mem_wmask), 32'h0);
    chk("d_resp_after", 32'(dmem_resp), 32'h0);
    dmem_wmask = 4'h0;

    // Fetch drops its mask mid-transaction
    step(); imem_addr = 32'h6000_0040; imem_rmask = 4'hf;
    step(); @(negedge clk); chk("drop_rmask_issue", 32'(mem_rmask), 32'hf);
    step(); imem_rmask = 4'h0;
    @(negedge clk);
    chk("drop_addr", mem_addr, 32'h6000_0040);
    chk("drop_rmask_held", 32'(mem_rmask), 32'hf);
    step(); mem_resp = 1'b1; mem_rdata = 32'haaaa_5555;
    @(negedge clk);
    chk("drop_resp", 32'(imem_resp), 32'h1);
    chk("drop_rdata", imem_rdata, 32'haaaa_5555);
    step(); mem_resp = 1'b0;
    @(negedge clk);
    chk("drop_resp_after", 32'(imem_resp), 32'h0);
    chk("drop_rmask_after", 32'(mem_rmask), 32'h0);

    // Reset while a data read is in flight, then a stale response
    step(); dmem_addr = 32'h2000; dmem_rmask = 4'hf;
    step(); @(negedge clk); chk("rmid_busy_rmask", 32'(mem_rmask), 32'hf);
    rst = 1'b1;
    #1;
    chk("rmid_rmask", 32'(mem_rmask), 32'h0);
    chk("rmid_wmask", 32'(mem_wmask), 32'h0);
    step(); dmem_rmask = 4'h0;
    @(negedge clk); rst = 1'b0;
    step(); mem_resp = 1'b1; mem_rdata = 32'hffff_ffff;
    @(negedge clk);
    chk("stale_iresp", 32'(imem_resp), 32'h0);
    chk("stale_dresp", 32'(dmem_resp), 32'h0);
    step(); mem_resp = 1'b0;

    // Idle with stray responses
    for (int k = 0; k < 10; k++) begin
      step(); mem_resp = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      @(negedge clk);
      chk("idle_rmask", 32'(mem_rmask), 32'h0);
      chk("idle_wmask", 32'(mem_wmask), 32'h0);
      chk("idle_iresp", 32'(imem_resp), 32'h0);
      chk("idle_dresp", 32'(dmem_resp), 32'h0);
    end
    step(); mem_resp = 1'b0;

    // Continuous contention: four data grants, then one fetch grant
    do_reset();
    run(40, 1'b1);
    chk("cont_grant_count", 32'(glog.size() >= 10), 32'h1);
    for (int k = 0; k < 10 && k < glog.size(); k++)
      chk($sformatf("cont_grant_%0d_is_i", k), 32'(glog[k]), 32'((k % 5) == 4));

    // Randomized traffic
    do_reset();
    run(2000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
